finn_rtl_krnl_example_pattern_generator: RTL and testbench

//  Runtime-configurable AXI4-Stream test-pattern source for the kernel example datapath.

---
 rtl/finn_rtl_krnl_example_pattern_pkg.sv | 37 +++
 rtl/finn_rtl_krnl_example_pattern_lane.sv | 73 +++++++
 rtl/finn_rtl_krnl_example_pattern_generator.sv | 138 +++++++++++++
 tb/tb_finn_rtl_krnl_example_pattern_generator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/finn_rtl_krnl_example_pattern_pkg.sv
// Shared types and constants for the kernel example test-pattern generator.
package finn_rtl_krnl_example_pattern_pkg;

  // Pattern selection; the reserved encoding behaves like incrementing data.
  typedef enum logic [1:0] {
    PAT_INCR  = 2'b00,
    PAT_CONST = 2'b01,
    PAT_LFSR  = 2'b10,
    PAT_RSVD  = 2'b11
  } pat_mode_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } pat_state_e;

  // Galois (right-shift) feedback masks, maximal length for the listed widths.
  localparam logic [7:0]  LP_LFSR_POLY_8  = 8'hB8;
  localparam logic [15:0] LP_LFSR_POLY_16 = 16'hB400;
  localparam logic [31:0] LP_LFSR_POLY_32 = 32'h8020_0003;
  localparam logic [63:0] LP_LFSR_POLY_64 = 64'hD800_0000_0000_0000;

  // Feedback mask lookup by lane width. Widths outside the table only get the
  // top tap, which keeps the register non-zero but is not maximal length.
  function automatic logic [63:0] lfsr_poly(input int unsigned width);
    case (width)
      8:       return {56'd0, LP_LFSR_POLY_8};
      16:      return {48'd0, LP_LFSR_POLY_16};
      32:      return {32'd0, LP_LFSR_POLY_32};
      64:      return LP_LFSR_POLY_64;
      default: return 64'd1 << (width - 1);
    endcase
  endfunction

endpackage

// File: rtl/finn_rtl_krnl_example_pattern_lane.sv
// One lane of the pattern generator: holds the lane value, loads it at the
// start of a transfer and advances it on every accepted beat.
module finn_rtl_krnl_example_pattern_lane
  import finn_rtl_krnl_example_pattern_pkg::*;
#(
  parameter int unsigned C_NUMBER_BIT_WIDTH = 32,
  parameter int unsigned C_NUM_LANES        = 4,
  parameter int unsigned C_LANE_INDEX       = 0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          load_i,
  input  logic                          advance_i,
  input  pat_mode_e                     load_mode_i,
  input  pat_mode_e                     run_mode_i,
  input  logic [C_NUMBER_BIT_WIDTH-1:0] seed_i,
  input  logic [C_NUMBER_BIT_WIDTH-1:0] stride_i,
  output logic [C_NUMBER_BIT_WIDTH-1:0] value_o
);

  localparam int unsigned W = C_NUMBER_BIT_WIDTH;

  localparam logic [63:0]  LP_POLY_FULL  = lfsr_poly(W);
  localparam logic [63:0]  LP_IDX_FULL   = 64'(C_LANE_INDEX);
  localparam logic [63:0]  LP_LANES_FULL = 64'(C_NUM_LANES);
  localparam logic [W-1:0] LP_POLY       = LP_POLY_FULL[W-1:0];
  localparam logic [W-1:0] LP_IDX        = LP_IDX_FULL[W-1:0];
  localparam logic [W-1:0] LP_NUM_LANES  = LP_LANES_FULL[W-1:0];
  localparam logic [W-1:0] LP_ONE        = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] value_q, value_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] lfsrInit;

  // An all-zero LFSR would lock up, so a zero initial state is replaced by 1.
  // INCR lanes advance by one whole beat (lanes * stride), computed once at load.
  always_comb begin
    value_d  = value_q;
    step_d   = step_q;
    lfsrInit = seed_i ^ LP_IDX;
    if (lfsrInit == '0) begin
      lfsrInit = LP_ONE;
    end
    if (load_i) begin
      case (load_mode_i)
        PAT_CONST: value_d = seed_i;
        PAT_LFSR:  value_d = lfsrInit;
        default:   value_d = seed_i + LP_IDX * stride_i;
      endcase
      step_d = LP_NUM_LANES * stride_i;
    end else if (advance_i) begin
      case (run_mode_i)
        PAT_CONST: value_d = value_q;
        PAT_LFSR:  value_d = {1'b0, value_q[W-1:1]} ^ (value_q[0] ? LP_POLY : '0);
        default:   value_d = value_q + step_q;
      endcase
    end
  end

  // Lane value and per-beat increment registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      value_q <= '0;
      step_q  <= '0;
    end else begin
      value_q <= value_d;
      step_q  <= step_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/finn_rtl_krnl_example_pattern_generator.sv
// AXI4-Stream test-pattern source started and finished by the kernel control
// FSM via ap_start/ap_done. Holds the FSM, beat counter and tkeep/tlast logic.
module finn_rtl_krnl_example_pattern_generator
  import finn_rtl_krnl_example_pattern_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 128,
  parameter int unsigned C_NUMBER_BIT_WIDTH   = 32,
  parameter int unsigned C_LENGTH_WIDTH       = 32
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_done,
  output logic                              ap_idle,
  input  logic [C_LENGTH_WIDTH-1:0]         cfg_length_bytes,
  input  logic [1:0]                        cfg_mode,
  input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_seed,
  input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_stride,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                              m_axis_tlast
);

  localparam int unsigned LP_LANES = C_M_AXIS_TDATA_WIDTH / C_NUMBER_BIT_WIDTH;
  localparam int unsigned LP_BPB   = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned LP_REM_W = (LP_BPB > 1) ? $clog2(LP_BPB) : 1;

  localparam logic [C_LENGTH_WIDTH-1:0] LP_BPB_L = C_LENGTH_WIDTH'(LP_BPB);
  localparam logic [C_LENGTH_WIDTH-1:0] LP_ONE_L = C_LENGTH_WIDTH'(1);

  pat_state_e                state_q, state_d;
  pat_mode_e                 mode_q, mode_d;
  logic [C_LENGTH_WIDTH-1:0] beats_q, beats_d;
  logic [LP_REM_W-1:0]       rem_q, rem_d;
  logic                      startPrev_q, startPrev_d;

  logic                      startEdge;
  logic                      load;
  logic                      handshake;
  logic                      lastBeat;
  logic [C_LENGTH_WIDTH-1:0] lenRem;
  logic [C_LENGTH_WIDTH-1:0] beatTotal;
  logic [LP_BPB-1:0]         keepLast;

  assign startEdge = ap_start & ~startPrev_q;
  assign load      = (state_q == S_IDLE) & startEdge;
  assign handshake = (state_q == S_RUN) & m_axis_tready;
  assign lastBeat  = (beats_q == LP_ONE_L);
  assign lenRem    = cfg_length_bytes % LP_BPB_L;
  assign beatTotal = (cfg_length_bytes / LP_BPB_L) + {{(C_LENGTH_WIDTH-1){1'b0}}, (lenRem != '0)};

  // Next-state logic: sample cfg on a start edge in IDLE, count beats down on
  // each handshake, and pass through DONE for a single cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    beats_d     = beats_q;
    rem_d       = rem_q;
    startPrev_d = ap_start;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          mode_d  = pat_mode_e'(cfg_mode);
          beats_d = beatTotal;
          rem_d   = lenRem[LP_REM_W-1:0];
          state_d = (cfg_length_bytes == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (handshake) begin
          beats_d = beats_q - LP_ONE_L;
          if (lastBeat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; the edge detector resets to 1 so a start held high
  // across reset release is not mistaken for a new request.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      mode_q      <= PAT_INCR;
      beats_q     <= '0;
      rem_q       <= '0;
      startPrev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      beats_q     <= beats_d;
      rem_q       <= rem_d;
      startPrev_q <= startPrev_d;
    end
  end

  // Byte enables for a short final beat: the low (len % BPB) bytes.
  always_comb begin
    keepLast = '0;
    for (int b = 0; b < LP_BPB; b++) begin
      keepLast[b] = (rem_q == '0) || (LP_REM_W'(b) < rem_q);
    end
  end

  assign m_axis_tvalid = (state_q == S_RUN);
  assign m_axis_tlast  = m_axis_tvalid & lastBeat;
  assign m_axis_tkeep  = m_axis_tvalid ? (lastBeat ? keepLast : '1) : '0;
  assign ap_done       = (state_q == S_DONE);
  assign ap_idle       = (state_q == S_IDLE);

  for (genvar g = 0; g < LP_LANES; g++) begin : gLane
    logic [C_NUMBER_BIT_WIDTH-1:0] laneValue;

    finn_rtl_krnl_example_pattern_lane #(
      .C_NUMBER_BIT_WIDTH (C_NUMBER_BIT_WIDTH),
      .C_NUM_LANES        (LP_LANES),
      .C_LANE_INDEX       (g)
    ) uLane (
      .aclk        (aclk),
      .areset      (areset),
      .load_i      (load),
      .advance_i   (handshake),
      .load_mode_i (pat_mode_e'(cfg_mode)),
      .run_mode_i  (mode_q),
      .seed_i      (cfg_seed),
      .stride_i    (cfg_stride),
      .value_o     (laneValue)
    );

    assign m_axis_tdata[g*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] = laneValue;
  end

endmodule

// File: tb/tb_finn_rtl_krnl_example_pattern_generator.sv
// Scoreboard testbench for the kernel example pattern generator.
module tb_finn_rtl_krnl_example_pattern_generator;

  localparam int TDATA = 128;
  localparam int NUMW  = 32;
  localparam int LENW  = 32;
  localparam int LANES = TDATA / NUMW;
  localparam int BPB   = TDATA / 8;
  localparam logic [31:0] POLY32 = 32'h8020_0003;

  typedef struct {
    logic [TDATA-1:0] data;
    logic [BPB-1:0]   keep;
    logic             last;
  } beat_t;

  logic             aclk = 1'b0;
  logic             areset;
  logic             apStart;
  logic             apDone;
  logic             apIdle;
  logic [LENW-1:0]  cfgLength;
  logic [1:0]       cfgMode;
  logic [NUMW-1:0]  cfgSeed;
  logic [NUMW-1:0]  cfgStride;
  logic             tvalid;
  logic             tready;
  logic [TDATA-1:0] tdata;
  logic [BPB-1:0]   tkeep;
  logic             tlast;

  beat_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  always #5 aclk = ~aclk;

  finn_rtl_krnl_example_pattern_generator #(
    .C_M_AXIS_TDATA_WIDTH (TDATA),
    .C_NUMBER_BIT_WIDTH   (NUMW),
    .C_LENGTH_WIDTH       (LENW)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .ap_start         (apStart),
    .ap_done          (apDone),
    .ap_idle          (apIdle),
    .cfg_length_bytes (cfgLength),
    .cfg_mode         (cfgMode),
    .cfg_seed         (cfgSeed),
    .cfg_stride       (cfgStride),
    .m_axis_tvalid    (tvalid),
    .m_axis_tready    (tready),
    .m_axis_tdata     (tdata),
    .m_axis_tkeep     (tkeep),
    .m_axis_tlast     (tlast)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [TDATA-1:0] actual,
                             input logic [TDATA-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY32) : (s >> 1);
  endfunction

  // Reference model: builds the full expected beat sequence for one transfer.
  task automatic pushExpected(input logic [31:0] len, input logic [1:0] mode,
                              input logic [31:0] seed, input logic [31:0] stride);
    int          beats;
    int          remBytes;
    logic [31:0] st[LANES];
    beat_t       b;
    beats    = (int'(len) + BPB - 1) / BPB;
    remBytes = int'(len) % BPB;
    for (int i = 0; i < LANES; i++) begin
      st[i] = seed ^ 32'(i);
      if (st[i] == 32'd0) st[i] = 32'd1;
    end
    for (int k = 0; k < beats; k++) begin
      for (int i = 0; i < LANES; i++) begin
        case (mode)
          2'b01:   b.data[i*NUMW +: NUMW] = seed;
          2'b10:   b.data[i*NUMW +: NUMW] = st[i];
          default: b.data[i*NUMW +: NUMW] = seed + 32'(k * LANES + i) * stride;
        endcase
        st[i] = lfsrStep(st[i]);
      end
      b.last = (k == beats - 1);
      b.keep = (b.last && remBytes != 0) ? BPB'((1 << remBytes) - 1) : {BPB{1'b1}};
      expQ.push_back(b);
    end
  endtask

  // Runs one non-empty transfer with randomised backpressure and scoreboards it.
  task automatic applyStimulus(input logic [31:0] len, input logic [1:0] mode,
                               input logic [31:0] seed, input logic [31:0] stride,
                               input int readyPct, input bit toggleStart);
    beat_t            e;
    bit               stalled;
    bit               gotLast;
    int               cyc;
    int               limit;
    logic [TDATA-1:0] heldData;
    logic [BPB-1:0]   heldKeep;
    logic             heldLast;
    expQ.delete();
    pushExpected(len, mode, seed, stride);
    limit = expQ.size() * 40 + 20;
    @(negedge aclk);
    cfgLength = len; cfgMode = mode; cfgSeed = seed; cfgStride = stride;
    apStart = 1'b1; tready = 1'b0;
    @(negedge aclk);
    apStart   = 1'b0;
    cfgSeed   = ~seed;
    cfgStride = stride + 32'd7;
    cfgMode   = mode ^ 2'b01;
    cfgLength = len + 32'd3;
    stalled = 1'b0; gotLast = 1'b0; cyc = 0;
    heldData = '0; heldKeep = '0; heldLast = 1'b0;
    while (!gotLast && cyc < limit) begin
      checkOutput("tvalid_no_gap", tvalid, 1'b1);
      checkOutput("done_early", apDone, 1'b0);
      if (stalled) begin
        checkOutput("stall_data", tdata, heldData);
        checkOutput("stall_keep", tkeep, heldKeep);
        checkOutput("stall_last", tlast, heldLast);
      end
      tready = ($urandom_range(0, 99) < readyPct);
      if (toggleStart) apStart = 1'($urandom_range(0, 1));
      if (tvalid && tready && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("beat_data", tdata, e.data);
        checkOutput("beat_keep", tkeep, e.keep);
        checkOutput("beat_last", tlast, e.last);
        gotLast = e.last;
        stalled = 1'b0;
        if (gotLast) apStart = 1'b0;
      end else begin
        stalled  = tvalid;
        heldData = tdata; heldKeep = tkeep; heldLast = tlast;
      end
      @(negedge aclk);
      cyc++;
    end
    apStart = 1'b0;
    tready  = 1'b0;
    checkOutput("beats_left", expQ.size(), 0);
    checkOutput("tvalid_after_last", tvalid, 1'b0);
    checkOutput("done_pulse", apDone, 1'b1);
    @(negedge aclk);
    checkOutput("done_one_cycle", apDone, 1'b0);
    checkOutput("idle_after_done", apIdle, 1'b1);
    repeat (2) @(negedge aclk);
    checkOutput("no_restart", tvalid, 1'b0);
  endtask

  initial begin
    beat_t e;
    areset = 1'b1; apStart = 1'b0; tready = 1'b0;
    cfgLength = '0; cfgMode = '0; cfgSeed = '0; cfgStride = '0;
    repeat (3) @(negedge aclk);
    checkOutput("rst_tvalid", tvalid, 1'b0);
    checkOutput("rst_tlast", tlast, 1'b0);
    checkOutput("rst_done", apDone, 1'b0);
    checkOutput("rst_idle", apIdle, 1'b1);
    checkOutput("rst_tdata", tdata, '0);
    checkOutput("rst_tkeep", tkeep, '0);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    $display("[TB] incrementing, full beats and short final beat");
    applyStimulus(32'd64, 2'b00, 32'd0, 32'd1, 100, 1'b0);
    applyStimulus(32'd20, 2'b00, 32'd0, 32'd1, 100, 1'b0);
    applyStimulus(32'd16, 2'b00, 32'hFFFF_FFFE, 32'd1, 100, 1'b0);
    applyStimulus(32'd100, 2'b11, 32'd100, 32'd3, 60, 1'b0);

    $display("[TB] LFSR and constant under random backpressure");
    applyStimulus(32'd1024, 2'b10, 32'd1, 32'd0, 50, 1'b1);
    applyStimulus(32'd40, 2'b01, 32'hA5A5_5A5A, 32'd9, 50, 1'b0);

    $display("[TB] zero-length transfer");
    @(negedge aclk);
    cfgLength = '0; cfgMode = 2'b00; apStart = 1'b1;
    @(negedge aclk);
    checkOutput("len0_done", apDone, 1'b1);
    checkOutput("len0_tvalid", tvalid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checkOutput("len0_done_once", apDone, 1'b0);
      checkOutput("len0_no_restart", tvalid, 1'b0);
      checkOutput("len0_idle", apIdle, 1'b1);
    end
    apStart = 1'b0;

    $display("[TB] reset during transfer");
    expQ.delete();
    pushExpected(32'd128, 2'b00, 32'd5, 32'd2);
    @(negedge aclk);
    cfgLength = 32'd128; cfgMode = 2'b00; cfgSeed = 32'd5; cfgStride = 32'd2;
    apStart = 1'b1; tready = 1'b1;
    @(negedge aclk);
    apStart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = expQ.pop_front();
      checkOutput("pre_rst_data", tdata, e.data);
      checkOutput("pre_rst_valid", tvalid, 1'b1);
      @(negedge aclk);
    end
    areset = 1'b1; apStart = 1'b1;
    @(negedge aclk);
    checkOutput("abort_tvalid", tvalid, 1'b0);
    checkOutput("abort_tlast", tlast, 1'b0);
    checkOutput("abort_done", apDone, 1'b0);
    checkOutput("abort_idle", apIdle, 1'b1);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checkOutput("held_start_idle", apIdle, 1'b1);
      checkOutput("held_start_done", apDone, 1'b0);
    end
    apStart = 1'b0;
    tready  = 1'b0;
    applyStimulus(32'd48, 2'b10, 32'd0, 32'd0, 70, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
